gpr_wb_arbiter: RTL and testbench
=================================

Name: gpr_wb_arbiter

Overview:
Shares the single general-register write port between two write-back requesters: the ALU result path and the memory load path.
- Arbitration is fixed-priority with anti-starvation aging.
- Grants a one-cycle registered write slot to the register file.
- Keeps a per-register pending scoreboard, so decode can detect read-after-write hazards on its two read addresses.
- Sits between the execute/memory stages and the register file.

Parameters:
REG_NUM, 32, number of general registers (scoreboard depth)
ADDR_W, 5, register address width
DATA_W, 32, write data width
STARVE_MAX, 3, consecutive denied cycles of a pending ALU request before the ALU is forced to win

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
alu_req  input  1  ALU write-back request, held until granted
alu_addr  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
alu_gnt  output  1  ALU request accepted this cycle (combinational)
mem_req  input  1  load write-back request, held until granted
mem_addr  input  ADDR_W  load destination register
mem_data  input  DATA_W  load data
mem_gnt  output  1  load request accepted this cycle (combinational)
issue_valid  input  1  decode reserves a destination register this cycle
issue_addr  input  ADDR_W  reserved destination register
rd_addr_0  input  ADDR_W  decode read address 0
rd_addr_1  input  ADDR_W  decode read address 1
hazard_0  output  1  rd_addr_0 has a write pending
hazard_1  output  1  rd_addr_1 has a write pending
gpr_we_  output  1  register-file write enable, active low
gpr_wr_addr  output  ADDR_W  register-file write address
gpr_wr_data  output  DATA_W  register-file write data

Behaviour:
- Reset (asynchronous, active-high, on posedge reset) forces:
  - gpr_we_=1 (write disabled), gpr_wr_addr=0, gpr_wr_data=0;
  - starve counter=0;
  - all pending bits=0.
- While reset is asserted, alu_gnt=0 and mem_gnt=0, regardless of requests.
- Arbitration is combinational each cycle:
  - Only one request: that request is granted.
  - Both requests: mem wins, unless starve_cnt==STARVE_MAX, in which case alu wins.
  - At most one gnt is high per cycle. A gnt is never high without its req.
- Starve counter:
  - Increments (saturating at STARVE_MAX) in any cycle where alu_req=1 and alu_gnt=0.
  - Clears to 0 on an alu grant, and on any cycle where alu_req=0.
- Handshake:
  - A requester holds req, addr and data stable until it sees gnt.
  - It drops req, or presents the next item, in the cycle after gnt.
  - Back-to-back grants to the same requester are allowed.
- Write stage, latency 1:
  - On the clock edge after a grant in cycle N, gpr_we_=0 with the granted addr/data during cycle N+1.
  - If there is no grant in cycle N, gpr_we_=1 in cycle N+1 and addr/data hold their previous values.
  - Sustained throughput is one write per cycle.
- Scoreboard, pending[REG_NUM]:
  - Set at the clock edge when issue_valid=1, for bit issue_addr.
  - Cleared at the clock edge that ends a cycle with gpr_we_=0, for bit gpr_wr_addr; the write is committed in that cycle.
  - Set and clear on the same register in the same edge: set wins.
  - Issue to an already-pending register: the bit stays set. There is no counting; decode must not issue while a hazard is reported.
- Hazard outputs:
  - hazard_n = pending[rd_addr_n], combinational.
  - In the commit cycle (gpr_we_=0, gpr_wr_addr==rd_addr_n), hazard_n=0: the register file forwards the write data on read.
- A grant does not clear pending; only the commit does. The pending bit therefore stays set through the grant cycle.
- Reset mid-operation:
  - An in-flight granted write is dropped (gpr_we_ goes to 1 immediately).
  - The scoreboard is cleared.
  - Requesters observe no gnt until reset is released.

Test Plan:
- Reset check: assert reset mid-cycle with alu_req=1 -> gpr_we_=1, alu_gnt=0 and all hazards 0 immediately; after release, the first grant appears the same cycle and gpr_we_=0 the next cycle.
- Single requester: alu_req, addr=5, data=0x1234 in cycle 0 -> alu_gnt=1 in cycle 0; in cycle 1 gpr_we_=0, gpr_wr_addr=5, gpr_wr_data=0x1234; in cycle 2 gpr_we_=1.
- Contention and aging:
  - Stimulus: alu_req and mem_req both held continuously; mem presents a new item each cycle.
  - Required response: mem granted in cycles 0-2, alu granted in cycle 3 (STARVE_MAX=3), mem in cycles 4 onward; never two gnts in one cycle.
- Scoreboard:
  - Stimulus: issue_valid with addr=7 in cycle 0; rd_addr_0=7.
  - Required response: hazard_0=1 from cycle 1 until the commit cycle of the mem write to reg 7, 0 in the commit cycle, and the pending bit is clear afterwards.
- Same-edge set and clear: commit to reg 9 coincides with issue_valid, addr=9 -> pending[9] remains 1 and hazard stays high for rd_addr_1=9.
- Back-to-back writes to regs 1, 2, 3 from mem in consecutive cycles -> three consecutive gpr_we_=0 cycles with matching addr/data, and pending bits 1, 2, 3 clear in order.

Source files
------------

// File: rtl/gpr_wb_arbiter.sv
// Write-back arbiter for the single GPR write port: ALU vs load path with aging,
// one-cycle registered write slot, and a per-register pending scoreboard for decode.
module gpr_wb_arbiter #(
  parameter int unsigned REG_NUM    = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_req,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_gnt,
  input  logic              mem_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_gnt,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [ADDR_W-1:0] rd_addr_0,
  input  logic [ADDR_W-1:0] rd_addr_1,
  output logic              hazard_0,
  output logic              hazard_1,
  output logic              gpr_we_,
  output logic [ADDR_W-1:0] gpr_wr_addr,
  output logic [DATA_W-1:0] gpr_wr_data
);

  localparam int unsigned CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0]   starve_cnt;
  logic               starved;
  logic               commit;
  logic [REG_NUM-1:0] pending;
  logic [REG_NUM-1:0] pending_nxt;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < REG_NUM;
  endfunction

  assign starved = (starve_cnt == STARVE_LIM);
  assign commit  = ~gpr_we_;

  always_comb begin
    alu_gnt = 1'b0;
    mem_gnt = 1'b0;
    if (!reset) begin
      if (alu_req && (!mem_req || starved)) alu_gnt = 1'b1;
      else if (mem_req)                     mem_gnt = 1'b1;
    end
  end

  // Clear first, then set, so a same-edge issue to the committing register wins.
  always_comb begin
    pending_nxt = pending;
    if (commit && in_range(gpr_wr_addr))
      pending_nxt[gpr_wr_addr] = 1'b0;
    if (issue_valid && in_range(issue_addr))
      pending_nxt[issue_addr] = 1'b1;
  end

  // The commit cycle masks the hazard because the register file forwards on read.
  always_comb begin
    hazard_0 = in_range(rd_addr_0) && pending[rd_addr_0] &&
               !(commit && (gpr_wr_addr == rd_addr_0));
    hazard_1 = in_range(rd_addr_1) && pending[rd_addr_1] &&
               !(commit && (gpr_wr_addr == rd_addr_1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpr_we_     <= 1'b1;
      gpr_wr_addr <= '0;
      gpr_wr_data <= '0;
      starve_cnt  <= '0;
      pending     <= '0;
    end else begin
      gpr_we_ <= ~(alu_gnt | mem_gnt);
      if (alu_gnt) begin
        gpr_wr_addr <= alu_addr;
        gpr_wr_data <= alu_data;
      end else if (mem_gnt) begin
        gpr_wr_addr <= mem_addr;
        gpr_wr_data <= mem_data;
      end
      if (!alu_req || alu_gnt)
        starve_cnt <= '0;
      else if (!starved)
        starve_cnt <= starve_cnt + 1'b1;
      pending <= pending_nxt;
    end
  end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter: grants, aging, write stage, scoreboard and reset.
module tb_gpr_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        alu_req = 1'b0;
  logic [4:0]  alu_addr = '0;
  logic [31:0] alu_data = '0;
  logic        alu_gnt;
  logic        mem_req = 1'b0;
  logic [4:0]  mem_addr = '0;
  logic [31:0] mem_data = '0;
  logic        mem_gnt;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_addr = '0;
  logic [4:0]  rd_addr_0 = '0;
  logic [4:0]  rd_addr_1 = '0;
  logic        hazard_0;
  logic        hazard_1;
  logic        gpr_we_;
  logic [4:0]  gpr_wr_addr;
  logic [31:0] gpr_wr_data;

  int total = 0;
  int bad   = 0;

  gpr_wb_arbiter #(
    .REG_NUM(32), .ADDR_W(5), .DATA_W(32), .STARVE_MAX(3)
  ) dut (
    .clk(clk), .reset(reset),
    .alu_req(alu_req), .alu_addr(alu_addr), .alu_data(alu_data), .alu_gnt(alu_gnt),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_gnt(mem_gnt),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1),
    .hazard_0(hazard_0), .hazard_1(hazard_1),
    .gpr_we_(gpr_we_), .gpr_wr_addr(gpr_wr_addr), .gpr_wr_data(gpr_wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2 reset = 1'b1;
    tick(); tick();
    #1;
    chk("rst_we", 32'(gpr_we_), 32'd1);
    chk("rst_addr", 32'(gpr_wr_addr), 32'd0);
    chk("rst_data", gpr_wr_data, 32'd0);
    chk("rst_haz0", 32'(hazard_0), 32'd0);

    reset = 1'b0;
    tick();
    #1;
    chk("idle_gnt", {30'd0, alu_gnt, mem_gnt}, 32'd0);

    // single requester
    alu_req = 1'b1; alu_addr = 5'd5; alu_data = 32'h1234;
    #1;
    chk("single_gnt", {30'd0, alu_gnt, mem_gnt}, 32'd2);
    tick();
    alu_req = 1'b0;
    #1;
    chk("single_we", 32'(gpr_we_), 32'd0);
    chk("single_addr", 32'(gpr_wr_addr), 32'd5);
    chk("single_data", gpr_wr_data, 32'h1234);
    chk("single_gnt_off", 32'(alu_gnt), 32'd0);
    tick();
    #1;
    chk("single_we_off", 32'(gpr_we_), 32'd1);
    chk("single_hold", gpr_wr_data, 32'h1234);

    // contention and aging: mem wins 0-2, alu at 3, mem at 4
    alu_req = 1'b1; alu_addr = 5'd10; alu_data = 32'hAAAA;
    mem_req = 1'b1; mem_addr = 5'd11;
    for (int i = 0; i < 5; i++) begin
      mem_data = 32'(100 + i);
      #1;
      if (i == 3) chk("age_gnt", {30'd0, alu_gnt, mem_gnt}, 32'd2);
      else        chk("age_gnt", {30'd0, alu_gnt, mem_gnt}, 32'd1);
      if (i == 4) begin
        chk("age_wr_addr", 32'(gpr_wr_addr), 32'd10);
        chk("age_wr_data", gpr_wr_data, 32'hAAAA);
      end else if (i > 0) begin
        chk("age_wr_data", gpr_wr_data, 32'(100 + i - 1));
      end
      tick();
      if (i == 3) alu_req = 1'b0;
    end
    mem_req = 1'b0;
    #1;
    chk("age_last_data", gpr_wr_data, 32'd104);
    tick();
    #1;
    chk("age_idle_we", 32'(gpr_we_), 32'd1);

    // scoreboard on reg 7
    issue_valid = 1'b1; issue_addr = 5'd7; rd_addr_0 = 5'd7;
    #1;
    chk("sb_haz_pre", 32'(hazard_0), 32'd0);
    tick();
    issue_valid = 1'b0;
    #1;
    chk("sb_haz_set", 32'(hazard_0), 32'd1);
    tick();
    mem_req = 1'b1; mem_addr = 5'd7; mem_data = 32'd77;
    #1;
    chk("sb_grant", 32'(mem_gnt), 32'd1);
    chk("sb_haz_grant", 32'(hazard_0), 32'd1);
    tick();
    mem_req = 1'b0;
    #1;
    chk("sb_commit_we", 32'(gpr_we_), 32'd0);
    chk("sb_haz_commit", 32'(hazard_0), 32'd0);
    tick();
    #1;
    chk("sb_haz_after", 32'(hazard_0), 32'd0);

    // same-edge set and clear on reg 9
    issue_valid = 1'b1; issue_addr = 5'd9; rd_addr_1 = 5'd9;
    tick();
    issue_valid = 1'b0;
    mem_req = 1'b1; mem_addr = 5'd9; mem_data = 32'd99;
    #1;
    chk("se_haz_grant", 32'(hazard_1), 32'd1);
    tick();
    mem_req = 1'b0; issue_valid = 1'b1; issue_addr = 5'd9;
    #1;
    chk("se_commit_addr", 32'(gpr_wr_addr), 32'd9);
    chk("se_haz_commit", 32'(hazard_1), 32'd0);
    tick();
    issue_valid = 1'b0;
    #1;
    chk("se_haz_kept", 32'(hazard_1), 32'd1);
    tick();
    #1;
    chk("se_haz_kept2", 32'(hazard_1), 32'd1);

    // back-to-back commits to regs 1,2,3
    issue_valid = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      issue_addr = 5'(r);
      tick();
    end
    issue_valid = 1'b0;
    mem_req = 1'b1; mem_addr = 5'd1; mem_data = 32'd11;
    #1;
    chk("b2b_gnt1", 32'(mem_gnt), 32'd1);
    tick();
    mem_addr = 5'd2; mem_data = 32'd22; rd_addr_0 = 5'd1; rd_addr_1 = 5'd2;
    #1;
    chk("b2b_we1", 32'(gpr_we_), 32'd0);
    chk("b2b_addr1", 32'(gpr_wr_addr), 32'd1);
    chk("b2b_data1", gpr_wr_data, 32'd11);
    chk("b2b_haz_1", {30'd0, hazard_0, hazard_1}, 32'd1);
    tick();
    mem_addr = 5'd3; mem_data = 32'd33; rd_addr_0 = 5'd3; rd_addr_1 = 5'd2;
    #1;
    chk("b2b_we2", 32'(gpr_we_), 32'd0);
    chk("b2b_addr2", 32'(gpr_wr_addr), 32'd2);
    chk("b2b_data2", gpr_wr_data, 32'd22);
    chk("b2b_haz_2", {30'd0, hazard_0, hazard_1}, 32'd2);
    tick();
    mem_req = 1'b0; rd_addr_0 = 5'd2; rd_addr_1 = 5'd3;
    #1;
    chk("b2b_we3", 32'(gpr_we_), 32'd0);
    chk("b2b_addr3", 32'(gpr_wr_addr), 32'd3);
    chk("b2b_data3", gpr_wr_data, 32'd33);
    chk("b2b_haz_3", {30'd0, hazard_0, hazard_1}, 32'd0);
    tick();
    rd_addr_0 = 5'd3; rd_addr_1 = 5'd1;
    #1;
    chk("b2b_idle_we", 32'(gpr_we_), 32'd1);
    chk("b2b_haz_clr", {30'd0, hazard_0, hazard_1}, 32'd0);

    // reset mid-operation; reg 9 is still pending here
    rd_addr_0 = 5'd9;
    alu_req = 1'b1; alu_addr = 5'd4; alu_data = 32'd44;
    #1;
    chk("mr_haz_pre", 32'(hazard_0), 32'd1);
    chk("mr_gnt_pre", 32'(alu_gnt), 32'd1);
    tick();
    #1;
    chk("mr_inflight", 32'(gpr_we_), 32'd0);
    reset = 1'b1;
    #1;
    chk("mr_we", 32'(gpr_we_), 32'd1);
    chk("mr_gnt", {30'd0, alu_gnt, mem_gnt}, 32'd0);
    chk("mr_haz", {30'd0, hazard_0, hazard_1}, 32'd0);
    chk("mr_addr", 32'(gpr_wr_addr), 32'd0);
    tick();
    #1;
    chk("mr_gnt_hold", 32'(alu_gnt), 32'd0);
    reset = 1'b0;
    #1;
    chk("mr_rel_gnt", 32'(alu_gnt), 32'd1);
    tick();
    alu_req = 1'b0;
    #1;
    chk("mr_rel_we", 32'(gpr_we_), 32'd0);
    chk("mr_rel_addr", 32'(gpr_wr_addr), 32'd4);
    chk("mr_rel_data", gpr_wr_data, 32'd44);
    chk("mr_haz_clear", 32'(hazard_0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
